// File: rtl/mitchell_err_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// mitchell_err_sweep_ctrl
//
// Exhaustive error-characterisation sequencer for an approximate N-bit unsigned
// multiplier. After an accepted start it drives every operand pair (x, y) of
// [0, 2^N)^2 into the multiplier under test, one pair per cycle with x as the
// outer loop. It compares each returned product against the exact product and
// accumulates error statistics, which stay readable until the next sweep.
//
// Parameters
//   N         operand width; products and error distances are 2N bits wide
//   PIPE_LAT  multiplier latency in cycles (0 = combinational multiplier)
//
// Ports
//   clk      in   1     clock, rising edge
//   rst      in   1     synchronous active-high reset (aborts a running sweep)
//   start    in   1     sweep request, accepted only while idle
//   busy     out  1     sweep in progress (issuing pairs or draining)
//   done     out  1     one-cycle pulse; statistics are final in this cycle
//   mul_x    out  N     operand X to the multiplier (registered)
//   mul_y    out  N     operand Y to the multiplier (registered)
//   mul_p    in   2N    multiplier product, valid PIPE_LAT cycles after operands
//   err_sum  out  4N    sum of |mul_p - x*y| over all pairs
//   err_cnt  out  2N+1  number of pairs with a nonzero error distance
//   max_err  out  2N    largest error distance seen
//   max_x    out  N     X of the first pair that reached max_err
//   max_y    out  N     Y of the first pair that reached max_err
// -----------------------------------------------------------------------------
module mitchell_err_sweep_ctrl #(
  parameter int N        = 8,
  parameter int PIPE_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     mul_x,
  output logic [N-1:0]     mul_y,
  input  logic [2*N-1:0]   mul_p,
  output logic [4*N-1:0]   err_sum,
  output logic [2*N:0]     err_cnt,
  output logic [2*N-1:0]   max_err,
  output logic [N-1:0]     max_x,
  output logic [N-1:0]     max_y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Drain counter only needs to count to PIPE_LAT-1; keep at least one bit.
  localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_LAT > 0 ? PIPE_LAT - 1 : 0);
  localparam logic [2*N-1:0] K_LAST     = '1;
  // Delay-line word: {valid, x, y}
  localparam int TW = 2 * N + 1;

  state_t           state_q, state_d;
  logic [2*N-1:0]   k_q, k_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic             clear_stats;

  logic [4*N-1:0]   err_sum_q, err_sum_d;
  logic [2*N:0]     err_cnt_q, err_cnt_d;
  logic [2*N-1:0]   max_err_q, max_err_d;
  logic [N-1:0]     max_x_q, max_x_d;
  logic [N-1:0]     max_y_q, max_y_d;

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_d     = drain_q;
    clear_stats = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          k_d         = '0;
          clear_stats = 1'b1;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          // Index stops at the last pair so the operands hold (2^N-1, 2^N-1).
          drain_d = '0;
          state_d = (PIPE_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done  = (state_q == S_DONE);
  assign mul_x = k_q[2*N-1:N];
  assign mul_y = k_q[N-1:0];

  // ---------------------------------------------------------------------------
  // Operand delay line: aligns each pair with the product it produced.
  // The valid bit marks cycles in which a genuine pair was being issued.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] cur_w;
  logic [TW-1:0] tap_w;

  assign cur_w = {(state_q == S_RUN), k_q};

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign tap_w = cur_w;
    end else begin : g_dly
      for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
        logic [TW-1:0] stg_q;
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            if (rst) stg_q <= '0;
            else     stg_q <= cur_w;
          end
        end else begin : g_next
          always_ff @(posedge clk) begin
            if (rst) stg_q <= '0;
            else     stg_q <= g_stage[gi-1].stg_q;
          end
        end
      end
      assign tap_w = g_stage[PIPE_LAT-1].stg_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Error distance: magnitude compare first so the subtraction never wraps.
  // ---------------------------------------------------------------------------
  logic           tap_valid;
  logic [N-1:0]   tap_x, tap_y;
  logic [2*N-1:0] exact;
  logic [2*N-1:0] ed;
  logic           ed_nz;

  assign tap_valid = tap_w[2*N];
  assign tap_x     = tap_w[2*N-1:N];
  assign tap_y     = tap_w[N-1:0];
  assign exact     = {{N{1'b0}}, tap_x} * {{N{1'b0}}, tap_y};
  assign ed        = (mul_p >= exact) ? (mul_p - exact) : (exact - mul_p);
  assign ed_nz     = (ed != '0);

  // ---------------------------------------------------------------------------
  // Statistics accumulation
  // ---------------------------------------------------------------------------
  always_comb begin
    err_sum_d = err_sum_q;
    err_cnt_d = err_cnt_q;
    max_err_d = max_err_q;
    max_x_d   = max_x_q;
    max_y_d   = max_y_q;
    if (clear_stats) begin
      err_sum_d = '0;
      err_cnt_d = '0;
      max_err_d = '0;
      max_x_d   = '0;
      max_y_d   = '0;
    end else if (tap_valid) begin
      err_sum_d = err_sum_q + {{(2*N){1'b0}}, ed};
      err_cnt_d = err_cnt_q + {{(2*N){1'b0}}, ed_nz};
      // Strict compare: on a tie the earliest pair in sweep order is kept.
      if (ed > max_err_q) begin
        max_err_d = ed;
        max_x_d   = tap_x;
        max_y_d   = tap_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sum_q <= '0;
      err_cnt_q <= '0;
      max_err_q <= '0;
      max_x_q   <= '0;
      max_y_q   <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      err_cnt_q <= err_cnt_d;
      max_err_q <= max_err_d;
      max_x_q   <= max_x_d;
      max_y_q   <= max_y_d;
    end
  end

  assign err_sum = err_sum_q;
  assign err_cnt = err_cnt_q;
  assign max_err = max_err_q;
  assign max_x   = max_x_q;
  assign max_y   = max_y_q;

endmodule

// File: tb/tb_mitchell_err_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mitchell_err_sweep_ctrl.
// Three controller instances share one clock and reset:
//   sel 0: N=2, PIPE_LAT=0, behavioural multiplier chosen by 'mode'
//   sel 1: N=2, PIPE_LAT=2, same behavioural multiplier behind a 2-stage pipe
//   sel 2: N=8, PIPE_LAT=0, behavioural Mitchell log multiplier
// Multiplier modes: 0 exact, 1 constant zero, 2 exact plus one at (3,2).
// -----------------------------------------------------------------------------
module tb_mitchell_err_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_drv;
  int   sel;
  int   mode;

  // ---------------- instance 0: N=2, PIPE_LAT=0 ----------------
  logic       start0, busy0, done0;
  logic [1:0] x0, y0, mx0, my0;
  logic [3:0] p0, me0;
  logic [7:0] sum0;
  logic [4:0] cnt0;

  // ---------------- instance 1: N=2, PIPE_LAT=2 ----------------
  logic       start1, busy1, done1;
  logic [1:0] x1, y1, mx1, my1;
  logic [3:0] p1, me1, p1a, p1b;
  logic [7:0] sum1;
  logic [4:0] cnt1;

  // ---------------- instance 2: N=8, PIPE_LAT=0 ----------------
  logic        start2, busy2, done2;
  logic [7:0]  x2, y2, mx2, my2;
  logic [15:0] p2, me2;
  logic [31:0] sum2;
  logic [16:0] cnt2;

  assign start0 = start_drv && (sel == 0);
  assign start1 = start_drv && (sel == 1);
  assign start2 = start_drv && (sel == 2);

  mitchell_err_sweep_ctrl #(.N(2), .PIPE_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .mul_x(x0), .mul_y(y0), .mul_p(p0), .err_sum(sum0), .err_cnt(cnt0),
    .max_err(me0), .max_x(mx0), .max_y(my0)
  );

  mitchell_err_sweep_ctrl #(.N(2), .PIPE_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mul_x(x1), .mul_y(y1), .mul_p(p1), .err_sum(sum1), .err_cnt(cnt1),
    .max_err(me1), .max_x(mx1), .max_y(my1)
  );

  mitchell_err_sweep_ctrl #(.N(8), .PIPE_LAT(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mul_x(x2), .mul_y(y2), .mul_p(p2), .err_sum(sum2), .err_cnt(cnt2),
    .max_err(me2), .max_x(mx2), .max_y(my2)
  );

  // ---------------- behavioural multipliers ----------------
  function automatic logic [3:0] model2(input logic [1:0] a, input logic [1:0] b, input int m);
    logic [3:0] r;
    r = {2'b00, a} * {2'b00, b};
    case (m)
      1:       r = 4'd0;
      2:       if (a == 2'd3 && b == 2'd2) r = r + 4'd1;
      default: ;
    endcase
    return r;
  endfunction

  // Mitchell: log2(v) ~ k + f, with f the bits below the leading one.
  function automatic logic [15:0] mitchell8(input logic [7:0] a, input logic [7:0] b);
    int     ka, kb;
    longint fa, fb, s, p;
    if (a == 8'd0 || b == 8'd0) return 16'd0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    fa = (longint'(a) - (longint'(1) << ka)) << (8 - ka);
    fb = (longint'(b) - (longint'(1) << kb)) << (8 - kb);
    s  = fa + fb;
    if (s < 256) p = ((256 + s) << (ka + kb)) >> 8;
    else         p = (s << (ka + kb + 1)) >> 8;
    return 16'(p);
  endfunction

  assign p0 = model2(x0, y0, mode);
  always @(posedge clk) begin
    p1a <= model2(x1, y1, mode);
    p1b <= p1a;
  end
  assign p1 = p1b;
  assign p2 = mitchell8(x2, y2);

  // ---------------- observation mux ----------------
  logic        obs_busy, obs_done;
  logic [63:0] obs_x, obs_y, obs_sum, obs_cnt, obs_me, obs_mx, obs_my;

  always_comb begin
    obs_busy = 1'b0; obs_done = 1'b0;
    obs_x = '0; obs_y = '0; obs_sum = '0; obs_cnt = '0;
    obs_me = '0; obs_mx = '0; obs_my = '0;
    case (sel)
      0: begin
        obs_busy = busy0; obs_done = done0; obs_x = 64'(x0); obs_y = 64'(y0);
        obs_sum = 64'(sum0); obs_cnt = 64'(cnt0); obs_me = 64'(me0);
        obs_mx = 64'(mx0); obs_my = 64'(my0);
      end
      1: begin
        obs_busy = busy1; obs_done = done1; obs_x = 64'(x1); obs_y = 64'(y1);
        obs_sum = 64'(sum1); obs_cnt = 64'(cnt1); obs_me = 64'(me1);
        obs_mx = 64'(mx1); obs_my = 64'(my1);
      end
      default: begin
        obs_busy = busy2; obs_done = done2; obs_x = 64'(x2); obs_y = 64'(y2);
        obs_sum = 64'(sum2); obs_cnt = 64'(cnt2); obs_me = 64'(me2);
        obs_mx = 64'(mx2); obs_my = 64'(my2);
      end
    endcase
  end

  // ---------------- checking infrastructure ----------------
  typedef struct {
    int          id;
    int          sel;
    int          mode;
    logic [63:0] sum;
    logic [63:0] cnt;
    logic [63:0] me;
    logic [63:0] mx;
    logic [63:0] my;
    int          lat;
    logic [63:0] last;
  } exp_t;

  exp_t tbl[5];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   excl_viol = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0d expected %0d", nm, act, req);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(obs_busy), 64'd0);
    check({tag, "_done"}, 64'(obs_done), 64'd0);
    check({tag, "_x"},    obs_x,   64'd0);
    check({tag, "_y"},    obs_y,   64'd0);
    check({tag, "_sum"},  obs_sum, 64'd0);
    check({tag, "_cnt"},  obs_cnt, 64'd0);
    check({tag, "_max"},  obs_me,  64'd0);
    check({tag, "_mx"},   obs_mx,  64'd0);
    check({tag, "_my"},   obs_my,  64'd0);
  endtask

  // Runs one sweep; disturb=1 re-pulses start in cycle 5 and in the DONE cycle.
  task automatic run_sweep(input exp_t e, input bit disturb);
    exp_t r;
    int   lat;
    bit   got;
    int   extra_done;
    sel  = e.sel;
    mode = e.mode;
    @(negedge clk);
    start_drv = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);                       // start edge t
    lat = 0;
    got = 1'b0;
    while (lat < e.lat + 40) begin
      @(negedge clk);
      lat++;                              // now in cycle t+lat
      start_drv = 1'b0;
      if (disturb && lat == 5) start_drv = 1'b1;
      if (obs_busy && obs_done) excl_viol++;
      if (lat == 1) check("busy_after_start", 64'(obs_busy), 64'd1);
      if (obs_done) begin
        got = 1'b1;
        break;
      end
    end
    r = sb_q.pop_front();
    if (!got) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("done_latency", 64'(lat),   64'(r.lat));
      check("err_sum",      obs_sum,    r.sum);
      check("err_cnt",      obs_cnt,    r.cnt);
      check("max_err",      obs_me,     r.me);
      check("max_x",        obs_mx,     r.mx);
      check("max_y",        obs_my,     r.my);
      check("hold_x",       obs_x,      r.last);
      check("hold_y",       obs_y,      r.last);
      $display("sweep id=%0d sel=%0d mode=%0d lat=%0d sum=%0d cnt=%0d max=%0d at (%0d,%0d)",
               r.id, r.sel, r.mode, lat, obs_sum, obs_cnt, obs_me, obs_mx, obs_my);
      if (disturb) start_drv = 1'b1;      // start during DONE must be ignored
      @(negedge clk);
      start_drv = 1'b0;
      check("idle_after_done_busy", 64'(obs_busy), 64'd0);
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
        if (obs_done || obs_busy) extra_done++;
        @(negedge clk);
      end
      check("no_extra_activity", 64'(extra_done), 64'd0);
      check("sum_held", obs_sum, r.sum);
      check("max_held", obs_me,  r.me);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e8;
    logic [63:0] s8, c8, m8, mx8, my8, ex, pp, ed;
    int          lat;
    int          dn;

    rst = 1'b1; start_drv = 1'b0; sel = 0; mode = 0;

    //          id sel mode sum cnt max mx my lat last
    tbl[0] = '{0, 0, 0,  0,  0, 0, 0, 0, 17, 3};
    tbl[1] = '{1, 0, 1, 36,  9, 9, 3, 3, 17, 3};
    tbl[2] = '{2, 1, 2,  1,  1, 1, 3, 2, 19, 3};
    tbl[3] = '{3, 1, 1, 36,  9, 9, 3, 3, 19, 3};
    tbl[4] = '{4, 0, 2,  1,  1, 1, 3, 2, 17, 3};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    sel = 2;
    check_reset_outputs("rst2");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_sweep(tbl[i], 1'b0);

    // Start re-pulsed mid-sweep and in DONE: results must match the clean run.
    run_sweep(tbl[1], 1'b1);
    run_sweep(tbl[2], 1'b1);

    // Reset in the middle of a sweep aborts it without a done pulse.
    sel = 0; mode = 1;
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      start_drv = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrun_rst");
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (obs_done || obs_busy) dn++;
      @(negedge clk);
    end
    check("no_done_after_abort", 64'(dn), 64'd0);
    run_sweep(tbl[1], 1'b0);

    // Full N=8 sweep against a software sweep of the Mitchell model.
    s8 = '0; c8 = '0; m8 = '0; mx8 = '0; my8 = '0;
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 256; yi++) begin
        ex = 64'(xi * yi);
        pp = 64'(mitchell8(8'(xi), 8'(yi)));
        ed = (pp > ex) ? pp - ex : ex - pp;
        s8 = s8 + ed;
        if (ed != 0) c8 = c8 + 1;
        if (ed > m8) begin
          m8 = ed; mx8 = 64'(xi); my8 = 64'(yi);
        end
      end
    end
    e8 = '{5, 2, 0, s8, c8, m8, mx8, my8, 65537, 255};
    run_sweep(e8, 1'b0);

    check("busy_done_exclusive", 64'(excl_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
